// File: rtl/id_stage.sv
// Instruction-decode stage: field decode, 4-entry busy scoreboard for RAW/WAW stalls, ID/EX register.
// Optional macro WB_BYPASS_EN forwards the writeback value to a source read in the writeback cycle.
module id_stage #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_valid,
    input  logic [15:0]       if_instr,
    input  logic [PC_W-1:0]   if_pc,
    output logic              if_ready,
    output logic [1:0]        r_enc_0,
    output logic [1:0]        r_enc_1,
    input  logic [DATA_W-1:0] reg_out_0,
    input  logic [DATA_W-1:0] reg_out_1,
    input  logic              wb_we,
    input  logic [1:0]        wb_enc,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [3:0]        ex_op,
    output logic [1:0]        ex_rd,
    output logic              ex_we,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_imm,
    output logic [PC_W-1:0]   ex_pc,
    output logic              ex_illegal,
    output logic [CNT_W-1:0]  stall_cnt
);
    logic [3:0] op;
    logic [1:0] rd, ra, rb;
    logic [7:0] imm8;

    assign op   = if_instr[15:12];
    assign rd   = if_instr[11:10];
    assign ra   = if_instr[9:8];
    assign rb   = if_instr[7:6];
    assign imm8 = if_instr[7:0];

    assign r_enc_0 = ra;
    assign r_enc_1 = rb;

    logic reads_a, reads_b, writes, uses_imm, illegal;

    always_comb begin
        reads_a  = 1'b0;
        reads_b  = 1'b0;
        writes   = 1'b0;
        uses_imm = 1'b0;
        illegal  = 1'b0;
        case (op)
            4'd0: ;
            4'd1, 4'd2, 4'd3, 4'd4: begin
                reads_a = 1'b1;
                reads_b = 1'b1;
                writes  = 1'b1;
            end
            4'd5: begin
                reads_a  = 1'b1;
                writes   = 1'b1;
                uses_imm = 1'b1;
            end
            4'd6: begin
                writes   = 1'b1;
                uses_imm = 1'b1;
            end
            4'd7, 4'd8: begin
                reads_a = 1'b1;
                reads_b = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    logic              ex_valid_reg, ex_we_reg, ex_illegal_reg;
    logic [3:0]        ex_op_reg;
    logic [1:0]        ex_rd_reg;
    logic [DATA_W-1:0] ex_a_reg, ex_b_reg, ex_imm_reg;
    logic [PC_W-1:0]   ex_pc_reg;
    logic [CNT_W-1:0]  stall_cnt_reg;
    logic [3:0]        busy_reg, busy_next, pend, wb_hit;
    logic              handoff;

    assign handoff = ex_valid_reg & ex_ready & ex_we_reg;

    // Per-register pending state; a set from the EX handoff beats a writeback clear.
    for (genvar gi = 0; gi < 4; gi++) begin : g_reg
        logic in_ex;
        assign in_ex      = ex_valid_reg & ex_we_reg & (ex_rd_reg == 2'(gi));
        assign wb_hit[gi] = wb_we & (wb_enc == 2'(gi));
`ifdef WB_BYPASS_EN
        assign pend[gi]   = (busy_reg[gi] & ~wb_hit[gi]) | in_ex;
`else
        assign pend[gi]   = busy_reg[gi] | in_ex;
`endif
        assign busy_next[gi] = (handoff && ex_rd_reg == 2'(gi)) ? 1'b1 :
                               wb_hit[gi] ? 1'b0 : busy_reg[gi];
    end

    logic [DATA_W-1:0] src_a, src_b;
`ifdef WB_BYPASS_EN
    assign src_a = wb_hit[ra] ? wb_wdata : reg_out_0;
    assign src_b = wb_hit[rb] ? wb_wdata : reg_out_1;
`else
    logic unused_wdata;
    assign unused_wdata = ^wb_wdata;
    assign src_a = reg_out_0;
    assign src_b = reg_out_1;
`endif

    logic hazard, load;
    assign hazard   = if_valid & ((reads_a & pend[ra]) | (reads_b & pend[rb]) | (writes & pend[rd]));
    assign load     = ~ex_valid_reg | ex_ready;
    assign if_ready = flush | (load & ~hazard);

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_reg   <= 1'b0;
            ex_op_reg      <= '0;
            ex_rd_reg      <= '0;
            ex_we_reg      <= 1'b0;
            ex_a_reg       <= '0;
            ex_b_reg       <= '0;
            ex_imm_reg     <= '0;
            ex_pc_reg      <= '0;
            ex_illegal_reg <= 1'b0;
            busy_reg       <= '0;
            stall_cnt_reg  <= '0;
        end else begin
            busy_reg <= busy_next;
            if (hazard && !flush && !(&stall_cnt_reg))
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            if (flush) begin
                ex_valid_reg <= 1'b0;
            end else if (if_valid && if_ready) begin
                ex_valid_reg   <= 1'b1;
                // Illegal opcodes travel down the pipe as a NOP with the flag raised.
                ex_op_reg      <= illegal ? 4'd0 : op;
                ex_rd_reg      <= rd;
                ex_we_reg      <= writes;
                ex_a_reg       <= reads_a ? src_a : '0;
                ex_b_reg       <= reads_b ? src_b : '0;
                ex_imm_reg     <= uses_imm ? {{(DATA_W-8){imm8[7]}}, imm8} : '0;
                ex_pc_reg      <= if_pc;
                ex_illegal_reg <= illegal;
            end else if (ex_ready) begin
                ex_valid_reg <= 1'b0;
            end
        end
    end

    assign ex_valid   = ex_valid_reg;
    assign ex_op      = ex_op_reg;
    assign ex_rd      = ex_rd_reg;
    assign ex_we      = ex_we_reg;
    assign ex_a       = ex_a_reg;
    assign ex_b       = ex_b_reg;
    assign ex_imm     = ex_imm_reg;
    assign ex_pc      = ex_pc_reg;
    assign ex_illegal = ex_illegal_reg;
    assign stall_cnt  = stall_cnt_reg;
endmodule

// File: tb/tb_id_stage.sv
// Directed-vector bench for id_stage with a tiny 4-entry reg_file model behind the read encodings.
module tb_id_stage;
    localparam int DATA_W = 32;
    localparam int PC_W   = 8;
    localparam int CNT_W  = 16;
`ifdef WB_BYPASS_EN
    localparam int STALLS = 3;
    localparam logic BYP  = 1'b1;
`else
    localparam int STALLS = 4;
    localparam logic BYP  = 1'b0;
`endif

    logic              clk, reset;
    logic              if_valid, if_ready;
    logic [15:0]       if_instr;
    logic [PC_W-1:0]   if_pc;
    logic [1:0]        r_enc_0, r_enc_1;
    logic [DATA_W-1:0] reg_out_0, reg_out_1;
    logic              wb_we;
    logic [1:0]        wb_enc;
    logic [DATA_W-1:0] wb_wdata;
    logic              flush, ex_ready, ex_valid, ex_we, ex_illegal;
    logic [3:0]        ex_op;
    logic [1:0]        ex_rd;
    logic [DATA_W-1:0] ex_a, ex_b, ex_imm;
    logic [PC_W-1:0]   ex_pc;
    logic [CNT_W-1:0]  stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    id_stage #(.DATA_W(DATA_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
        .r_enc_0(r_enc_0), .r_enc_1(r_enc_1), .reg_out_0(reg_out_0), .reg_out_1(reg_out_1),
        .wb_we(wb_we), .wb_enc(wb_enc), .wb_wdata(wb_wdata),
        .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ex_op(ex_op), .ex_rd(ex_rd), .ex_we(ex_we), .ex_a(ex_a), .ex_b(ex_b),
        .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_illegal(ex_illegal), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reg_file model: R0=10, R1=20 after reset, written by the writeback port.
    logic [DATA_W-1:0] rf [4];
    always @(posedge clk) begin
        if (reset) begin
            rf[0] <= 32'd10;
            rf[1] <= 32'd20;
            rf[2] <= 32'd0;
            rf[3] <= 32'd0;
        end else if (wb_we) begin
            rf[wb_enc] <= wb_wdata;
        end
    end
    assign reg_out_0 = rf[r_enc_0];
    assign reg_out_1 = rf[r_enc_1];

    always @(negedge clk)
        if (!reset && ex_valid && ex_ready)
            $display("xfer pc=%02h op=%0d rd=%0d we=%0d a=%08h b=%08h imm=%08h ill=%0d stalls=%0d",
                     ex_pc, ex_op, ex_rd, ex_we, ex_a, ex_b, ex_imm, ex_illegal, stall_cnt);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; if_valid = 1'b1; if_instr = 16'h1840; if_pc = 8'h10;
        wb_we = 1'b0; wb_enc = 2'd0; wb_wdata = '0; flush = 1'b0; ex_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", ex_valid, 0);
        check("rst_op", ex_op, 0);
        check("rst_rd", ex_rd, 0);
        check("rst_we", ex_we, 0);
        check("rst_a", ex_a, 0);
        check("rst_b", ex_b, 0);
        check("rst_imm", ex_imm, 0);
        check("rst_pc", ex_pc, 0);
        check("rst_ill", ex_illegal, 0);
        check("rst_stall", stall_cnt, 0);
        reset = 1'b0;

        // ADD R2,R0,R1
        #1;
        check("add_renc0", r_enc_0, 0);
        check("add_renc1", r_enc_1, 1);
        check("add_ready", if_ready, 1);
        step();
        check("add_valid", ex_valid, 1);
        check("add_op", ex_op, 1);
        check("add_rd", ex_rd, 2);
        check("add_we", ex_we, 1);
        check("add_a", ex_a, 10);
        check("add_b", ex_b, 20);
        check("add_imm", ex_imm, 0);
        check("add_pc", ex_pc, 8'h10);

        // LDI R1,#-3
        if_instr = 16'h64FD; if_pc = 8'h11;
        #1;
        check("ldi_ready", if_ready, 1);
        step();
        check("ldi_valid", ex_valid, 1);
        check("ldi_op", ex_op, 6);
        check("ldi_rd", ex_rd, 1);
        check("ldi_we", ex_we, 1);
        check("ldi_imm", ex_imm, 32'hFFFF_FFFD);
        check("ldi_a", ex_a, 0);
        check("ldi_pc", ex_pc, 8'h11);

        // ADD R3,R1,R0 depends on the LDI
        if_instr = 16'h1D00; if_pc = 8'h12;
        #1;
        check("raw_ex_ready", if_ready, 0);
        step();
        check("raw_c1_valid", ex_valid, 0);
        check("raw_c1_stall", stall_cnt, 1);
        check("raw_c1_ready", if_ready, 0);
        step();
        check("raw_c2_stall", stall_cnt, 2);
        check("raw_c2_ready", if_ready, 0);
        step();
        check("raw_c3_stall", stall_cnt, 3);
        wb_we = 1'b1; wb_enc = 2'd1; wb_wdata = 32'h55;
        #1;
        check("raw_wb_ready", if_ready, BYP);
        step();
        wb_we = 1'b0;
`ifndef WB_BYPASS_EN
        check("raw_wb_valid", ex_valid, 0);
        check("raw_wb_stall", stall_cnt, STALLS);
        #1;
        check("raw_post_ready", if_ready, 1);
        step();
`endif
        check("raw_valid", ex_valid, 1);
        check("raw_rd", ex_rd, 3);
        check("raw_a", ex_a, 32'h55);
        check("raw_b", ex_b, 10);
        check("raw_pc", ex_pc, 8'h12);
        check("raw_stall", stall_cnt, STALLS);

        // EX back-pressure for 4 cycles with ADDI R0,R0,#5 waiting
        ex_ready = 1'b0; if_instr = 16'h5005; if_pc = 8'h13;
        #1;
        check("bp_ready0", if_ready, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp_valid", ex_valid, 1);
            check("bp_rd", ex_rd, 3);
            check("bp_a", ex_a, 32'h55);
            check("bp_pc", ex_pc, 8'h12);
            check("bp_ready", if_ready, 0);
        end
        check("bp_stall", stall_cnt, STALLS);
        ex_ready = 1'b1;
        #1;
        check("bp_release", if_ready, 1);
        step();
        check("addi_op", ex_op, 5);
        check("addi_rd", ex_rd, 0);
        check("addi_a", ex_a, 10);
        check("addi_b", ex_b, 0);
        check("addi_imm", ex_imm, 5);
        check("addi_pc", ex_pc, 8'h13);

        // Flush kills ADDI (never handed off) and drops LDI R3
        ex_ready = 1'b0; flush = 1'b1; if_instr = 16'h6C07; if_pc = 8'h14;
        #1;
        check("fl_ready", if_ready, 1);
        step();
        check("fl_valid", ex_valid, 0);
        check("fl_stall", stall_cnt, STALLS);
        flush = 1'b0; ex_ready = 1'b1;

        // R3 still busy after the flush
        if_instr = 16'h1F00; if_pc = 8'h15;
        #1;
        check("fl_busy3", if_ready, 0);
        step();
        check("fl_busy_valid", ex_valid, 0);
        check("fl_busy_stall", stall_cnt, STALLS + 1);

        // Illegal opcode 0xC
        if_instr = 16'hC1FF; if_pc = 8'h16;
        #1;
        check("ill_ready", if_ready, 1);
        step();
        check("ill_valid", ex_valid, 1);
        check("ill_flag", ex_illegal, 1);
        check("ill_we", ex_we, 0);
        check("ill_imm", ex_imm, 0);
        check("ill_a", ex_a, 0);
        check("ill_pc", ex_pc, 8'h16);

        // ADDI R0,R0,#-1: R0 was never marked busy by the flushed ADDI
        if_instr = 16'h50FF; if_pc = 8'h17;
        #1;
        check("r0_free", if_ready, 1);
        step();
        check("addi2_op", ex_op, 5);
        check("addi2_a", ex_a, 10);
        check("addi2_imm", ex_imm, 32'hFFFF_FFFF);
        check("addi2_ill", ex_illegal, 0);
        check("addi2_we", ex_we, 1);

        if_valid = 1'b0;
        step();
        check("drain_valid", ex_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage of the pipelined CPU, directly upstream of reg_file.
- Accepts fetched instructions, decodes them and drives the reg_file read encodings.
- Performs RAW/WAW hazard checks with a 4-entry busy scoreboard and registers operands into an ID/EX pipeline register under a valid/ready handshake.

Parameters:
- DATA_W, 32, register/operand width; matches reg_file data width.
- PC_W, 8, program-counter width.
- CNT_W, 16, stall performance-counter width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- if_valid  in  1  fetch holds a valid instruction.
- if_instr  in  16  instruction word.
- if_pc  in  PC_W  PC of if_instr.
- if_ready  out  1  ID consumes the instruction this cycle.
- r_enc_0  out  2  reg_file read port 0 select (ra).
- r_enc_1  out  2  reg_file read port 1 select (rb).
- reg_out_0  in  DATA_W  reg_file read data 0.
- reg_out_1  in  DATA_W  reg_file read data 1.
- wb_we  in  1  writeback write enable (same net as reg_file we).
- wb_enc  in  2  writeback destination (same as r_write_enc).
- wb_wdata  in  DATA_W  writeback data (same as wdata).
- flush  in  1  kill ID/EX contents and the current fetch.
- ex_ready  in  1  EX accepts the ID/EX contents.
- ex_valid  out  1  ID/EX register valid.
- ex_op  out  4  opcode.
- ex_rd  out  2  destination register.
- ex_we  out  1  instruction writes ex_rd.
- ex_a  out  DATA_W  operand A.
- ex_b  out  DATA_W  operand B.
- ex_imm  out  DATA_W  sign-extended imm8.
- ex_pc  out  PC_W  instruction PC.
- ex_illegal  out  1  undefined opcode (decoded as NOP).
- stall_cnt  out  CNT_W  saturating count of hazard-stall cycles.

Behaviour:
- Instruction fields: op=[15:12], rd=[11:10], ra=[9:8], rb=[7:6], imm8=[7:0].
- Opcode decode (reads / writes):
  - 0 NOP: none / none.
  - 1 ADD, 2 SUB, 3 AND, 4 OR: ra, rb / rd.
  - 5 ADDI: ra / rd.
  - 6 LDI: none / rd.
  - 7 ST: ra, rb / none.
  - 8 BEQ: ra, rb / none.
  - 9-15: illegal, decoded as NOP with ex_illegal=1.
- r_enc_0=ra and r_enc_1=rb, combinationally from if_instr at all times. reg_out_* are sampled at the same rising edge (zero-cycle read).
- busy[3:0] scoreboard:
  - Set bit ex_rd when ex_valid & ex_ready & ex_we (handoff to EX).
  - Clear bit wb_enc when wb_we.
  - Same bit set and cleared in one cycle: set wins.
- pend(r) = busy[r] | (ex_valid & ex_we & ex_rd==r).
- hazard = if_valid & ((reads ra & pend(ra)) | (reads rb & pend(rb)) | (writes rd & pend(rd))).
- load = ~ex_valid | ex_ready.
- if_ready = flush | (load & ~hazard).
- On the clock edge:
  - flush: ex_valid<=0; the fetched instruction is dropped; busy is unaffected.
  - else if if_valid & if_ready: the ID/EX register loads the decoded fields and ex_valid<=1.
  - else if ex_ready: ex_valid<=0.
  - else: hold all ID/EX contents.
- ex_a=reg_out_0 and ex_b=reg_out_1 for reading ops; 0 otherwise.
- ex_imm = sign-extended imm8; 0 for non-immediate ops.
- Illegal op: loads with ex_we=0, ex_illegal=1.
- stall_cnt increments on every cycle with hazard & ~flush and saturates at all-ones.
- Reset: ex_valid, ex_op, ex_rd, ex_we, ex_a, ex_b, ex_imm, ex_pc, ex_illegal, busy and stall_cnt all 0. Reset overrides flush and any handshake; an in-flight ID/EX entry is discarded.
- Latency: 1 cycle from if_valid&if_ready to ex_valid.
- Throughput: 1 instruction/cycle with no hazards.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: a source equal to wb_enc with wb_we=1 in the same cycle is not counted pending via busy. Its operand takes wb_wdata instead of reg_out_*, so a dependent instruction issues in the writeback cycle.
- Undefined: no bypass; the instruction stalls until busy clears, then reads reg_file the following cycle.

Test Plan:
- Reset held 2 cycles with if_valid=1 -> ex_valid=0, all ex_* 0, stall_cnt=0, busy=0.
- LDI R1,#-3 (0x6_4FD) with ex_ready=1 -> next cycle ex_valid=1, ex_rd=1, ex_we=1, ex_imm=0xFFFFFFFD.
- ADD R2,R0,R1 with R0=10 and R1=20 in reg_file -> r_enc_0=0, r_enc_1=1, ex_a=10, ex_b=20.
- LDI R1 then ADD R3,R1,R0; wb_we for R1 asserted 3 cycles after LDI handoff:
  - if_ready=0 while R1 is pending; stall_cnt counts the stall cycles.
  - Without WB_BYPASS_EN: ADD issues the cycle after wb_we, with ex_a = new R1 value.
  - With WB_BYPASS_EN: ADD issues in the wb_we cycle, with ex_a=wb_wdata.
- ex_ready=0 for 4 cycles with valid ADD held -> ex_* stable, if_ready=0; ex_ready=1 -> next instruction loads.
- flush while ex_valid=1 and if_valid=1 -> next cycle ex_valid=0, busy unchanged; opcode 0xC -> ex_illegal=1, ex_we=0.
